// File: rtl/stream_mux_n_pkg.sv
// Shared constants and helpers for the N-channel stream multiplexer.
// Latency: none (declarations only).
// Backpressure: not applicable.
package stream_mux_n_pkg;

  // Legal channel-count range
  localparam int N_MIN = 2;
  localparam int N_MAX = 16;

  // Grant mode encoding on rr_en
  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Ceiling log2, used for elaboration-time width checks
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/stream_mux_n_rr_arbiter.sv
// Round-robin arbiter: picks the first requester after the last served channel.
// Latency: grant is combinational; the pointer updates one edge after an advance.
// Backpressure: the pointer only moves when advance_i is high (a real transfer).
module stream_mux_n_rr_arbiter
  import stream_mux_n_pkg::*;
#(
  parameter int N     = 2,
  parameter int SEL_W = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req_i,
  input  logic             advance_i,
  output logic [N-1:0]     gnt_o,
  output logic [SEL_W-1:0] gnt_idx_o,
  output logic             gnt_vld_o
);

  // Last-served channel; resets to N-1 so channel 0 is searched first
  logic [SEL_W-1:0] ptr_q;
  logic [SEL_W-1:0] ptr_d;

  // Search requests starting one past the pointer, wrapping around
  always_comb begin
    int cand;
    gnt_vld_o = 1'b0;
    gnt_idx_o = '0;
    cand      = 0;
    for (int k = 1; k <= N; k++) begin
      cand = (int'(ptr_q) + k) % N;
      if (!gnt_vld_o && req_i[cand]) begin
        gnt_vld_o = 1'b1;
        gnt_idx_o = SEL_W'(cand);
      end
    end
  end

  // One-hot form of the winning index
  always_comb begin
    gnt_o = '0;
    for (int i = 0; i < N; i++) begin
      gnt_o[i] = gnt_vld_o && (gnt_idx_o == SEL_W'(i));
    end
  end

  // Pointer follows the granted channel only when a word actually moves
  always_comb begin
    ptr_d = ptr_q;
    if (advance_i && gnt_vld_o) begin
      ptr_d = gnt_idx_o;
    end
  end

  // Pointer register
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= SEL_W'(N - 1);
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/stream_mux_n.sv
// N-channel registered stream mux with fixed-select or round-robin grant.
// Latency: 1 cycle from input transfer to out_valid.
// Backpressure: a held word with out_ready low freezes the register and drops all in_ready.
module stream_mux_n
  import stream_mux_n_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int N     = 2,
  parameter int SEL_W = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  input  logic [SEL_W-1:0]   sel,
  input  logic               rr_en,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid,
  output logic [SEL_W-1:0]   out_chan,
  input  logic               out_ready
);

  // Reject illegal parameter combinations at elaboration
  if (SEL_W != clog2(N)) begin : g_bad_sel_w
    $error("stream_mux_n: SEL_W must equal clog2(N)");
  end
  if (N < N_MIN || N > N_MAX) begin : g_bad_n
    $error("stream_mux_n: N out of legal range");
  end

  // sel can address up to 2**SEL_W channels; pad valid so any sel indexes safely
  localparam int NP = 1 << SEL_W;

  logic [NP-1:0]    vld_ext;
  logic             fix_vld;
  logic [N-1:0]     fix_oh;
  logic [N-1:0]     rr_oh;
  logic [SEL_W-1:0] rr_idx;
  logic             rr_vld;
  logic             grant_vld;
  logic [SEL_W-1:0] grant_idx;
  logic [N-1:0]     grant_oh;
  logic             load;
  logic             xfer;
  logic [WIDTH-1:0] grant_word;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic [SEL_W-1:0] out_chan_q,  out_chan_d;

  assign vld_ext = NP'(in_valid);

  // Register can take a word when empty or when draining this cycle
  assign load = !out_valid_q || out_ready;

  stream_mux_n_rr_arbiter #(
    .N     (N),
    .SEL_W (SEL_W)
  ) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req_i     (in_valid),
    .advance_i (xfer && (rr_en == MODE_RR)),
    .gnt_o     (rr_oh),
    .gnt_idx_o (rr_idx),
    .gnt_vld_o (rr_vld)
  );

  // Fixed-mode grant: only the selected channel counts, out-of-range sel grants nothing
  always_comb begin
    fix_vld = (32'(sel) < N) && vld_ext[sel];
    fix_oh  = '0;
    for (int i = 0; i < N; i++) begin
      fix_oh[i] = fix_vld && (sel == SEL_W'(i));
    end
  end

  // Pick the active mode's grant and form the handshake
  always_comb begin
    if (rr_en == MODE_RR) begin
      grant_vld = rr_vld;
      grant_idx = rr_idx;
      grant_oh  = rr_oh;
    end else begin
      grant_vld = fix_vld;
      grant_idx = sel;
      grant_oh  = fix_oh;
    end
    xfer     = load && grant_vld && !rst;
    in_ready = xfer ? grant_oh : '0;
  end

  // Data mux for the granted channel
  always_comb begin
    grant_word = '0;
    for (int i = 0; i < N; i++) begin
      if (grant_idx == SEL_W'(i)) begin
        grant_word = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Output register next state: load on transfer, empty on drain, else hold
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = grant_word;
      out_chan_d  = grant_idx;
    end else if (load) begin
      out_valid_d = 1'b0;
    end
  end

  // Output register
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_chan_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;

endmodule

// File: tb/tb_stream_mux_n.sv
// Bench for stream_mux_n: directed vectors, per-cycle model compare, literal checks.
// Latency: checks sample on the falling edge, inputs change 1 time unit after the rising edge.
// Backpressure: exercised with out_ready stalls and mid-stall reset.
module tb_stream_mux_n;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [1:0]  sel;
  logic        rr_en;
  logic [7:0]  out_data;
  logic        out_valid;
  logic [1:0]  out_chan;
  logic        out_ready;

  logic [23:0] in_data3;
  logic [2:0]  in_valid3;
  logic [2:0]  in_ready3;
  logic [1:0]  sel3;
  logic        rr_en3;
  logic [7:0]  out_data3;
  logic        out_valid3;
  logic [1:0]  out_chan3;
  logic        out_ready3;

  int checks = 0;
  int errors = 0;
  logic chk_en = 1'b0;

  always #5 clk = ~clk;

  stream_mux_n #(.WIDTH(8), .N(4), .SEL_W(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sel       (sel),
    .rr_en     (rr_en),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_chan  (out_chan),
    .out_ready (out_ready)
  );

  stream_mux_n #(.WIDTH(8), .N(3), .SEL_W(2)) dut3 (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data3),
    .in_valid  (in_valid3),
    .in_ready  (in_ready3),
    .sel       (sel3),
    .rr_en     (rr_en3),
    .out_data  (out_data3),
    .out_valid (out_valid3),
    .out_chan  (out_chan3),
    .out_ready (out_ready3)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model of the N=4 instance: register contents and last-served channel
  int         m_ptr;
  logic       m_valid;
  logic [7:0] m_data;
  int         m_chan;

  // Which channel the rules grant right now, -1 for none
  function automatic int model_grant();
    if (!rr_en) begin
      return in_valid[sel] ? int'(sel) : -1;
    end
    for (int k = 1; k <= 4; k++) begin
      int c;
      c = (m_ptr + k) % 4;
      if (in_valid[c]) return c;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    int g;
    g = model_grant();
    if (rst) begin
      m_valid = 1'b0;
      m_data  = 8'h00;
      m_chan  = 0;
      m_ptr   = 3;
    end else if ((!m_valid || out_ready) && g >= 0) begin
      m_valid = 1'b1;
      m_data  = in_data[g*8 +: 8];
      m_chan  = g;
      if (rr_en) m_ptr = g;
    end else if (!m_valid || out_ready) begin
      m_valid = 1'b0;
    end
  end

  always @(negedge clk) begin
    int g;
    logic [3:0] er;
    if (chk_en) begin
      g  = model_grant();
      er = (!rst && (!m_valid || out_ready) && g >= 0) ? 4'(1 << g) : 4'b0000;
      check("model in_ready",  32'(in_ready),  32'(er));
      check("model out_valid", 32'(out_valid), 32'(m_valid));
      check("model out_data",  32'(out_data),  32'(m_data));
      check("model out_chan",  32'(out_chan),  32'(m_chan));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  int rr_a[5] = '{1, 2, 3, 0, 1};
  int rr_b[6] = '{2, 3, 0, 2, 3, 0};

  initial begin
    rst        = 1'b1;
    in_data    = {8'hD4, 8'hA5, 8'h3C, 8'h11};
    in_valid   = 4'b1111;
    sel        = 2'd0;
    rr_en      = 1'b1;
    out_ready  = 1'b1;
    in_data3   = {8'h77, 8'h66, 8'h55};
    in_valid3  = 3'b111;
    sel3       = 2'd3;
    rr_en3     = 1'b0;
    out_ready3 = 1'b1;

    // Reset held for two edges with every channel requesting
    tick();
    chk_en = 1'b1;
    at_neg();
    check("rst in_ready", 32'(in_ready), 32'h0);
    check("rst out_valid", 32'(out_valid), 32'h0);
    tick();
    rst = 1'b0;
    at_neg();
    check("release in_ready ch0", 32'(in_ready), 32'h1);
    check("release out_data", 32'(out_data), 32'h0);
    tick();
    at_neg();
    check("first word chan", 32'(out_chan), 32'h0);
    check("first word data", 32'(out_data), 32'h11);
    check("n3 sel oob valid", 32'(out_valid3), 32'h0);
    check("n3 sel oob ready", 32'(in_ready3), 32'h0);

    // Round-robin, all channels requesting
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i == 4) in_valid = 4'b1101;
      at_neg();
      check("rr all chan", 32'(out_chan), 32'(rr_a[i]));
    end
    // Round-robin with channel 1 idle
    for (int i = 0; i < 6; i++) begin
      tick();
      at_neg();
      check("rr skip1 chan", 32'(out_chan), 32'(rr_b[i]));
    end

    // One more RR grant, then switch to fixed select of channel 1
    tick();
    rr_en = 1'b0;
    sel = 2'd1;
    in_valid = 4'b1111;
    at_neg();
    check("rr before fixed", 32'(out_chan), 32'h2);
    check("n3 still idle", 32'(out_valid3), 32'h0);
    tick();
    out_ready = 1'b0;
    at_neg();
    check("fixed data", 32'(out_data), 32'h3C);
    check("fixed chan", 32'(out_chan), 32'h1);
    check("stall ready", 32'(in_ready), 32'h0);

    // Stall with sel/rr_en toggling; release on the last cycle
    for (int i = 0; i < 3; i++) begin
      tick();
      case (i)
        0: begin sel = 2'd3; rr_en = 1'b1; end
        1: begin sel = 2'd0; rr_en = 1'b0; end
        default: begin sel = 2'd2; rr_en = 1'b1; out_ready = 1'b1; end
      endcase
      at_neg();
      check("stall data", 32'(out_data), 32'h3C);
      check("stall chan", 32'(out_chan), 32'h1);
      check("stall ready", 32'(in_ready), (i == 2) ? 32'h8 : 32'h0);
    end

    // Drain and reload in one cycle; pointer survived the fixed-mode excursion
    tick();
    in_valid = 4'b0000;
    sel3 = 2'd2;
    at_neg();
    check("reload chan", 32'(out_chan), 32'h3);
    check("reload data", 32'(out_data), 32'hD4);
    check("n3 sel2 ready", 32'(in_ready3), 32'h4);

    // Drain to empty
    tick();
    in_valid = 4'b0010;
    at_neg();
    check("drain valid", 32'(out_valid), 32'h0);
    check("drain data hold", 32'(out_data), 32'hD4);
    check("n3 data", 32'(out_data3), 32'h77);
    check("n3 chan", 32'(out_chan3), 32'h2);

    // Load channel 1, then stall and reset mid-stall
    tick();
    out_ready = 1'b0;
    at_neg();
    check("pre-rst valid", 32'(out_valid), 32'h1);
    check("pre-rst chan", 32'(out_chan), 32'h1);
    tick();
    rst = 1'b1;
    in_valid = 4'b1111;
    at_neg();
    check("rst stall ready", 32'(in_ready), 32'h0);
    tick();
    rst = 1'b0;
    at_neg();
    check("post-rst valid", 32'(out_valid), 32'h0);
    check("post-rst ready ch0", 32'(in_ready), 32'h1);
    tick();
    at_neg();
    check("post-rst chan", 32'(out_chan), 32'h0);
    check("post-rst data", 32'(out_data), 32'h11);

    tick();
    at_neg();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
